pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter START_PC, default 7'd0, meaning the PC value loaded on reset and on each accepted start.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the executed-instruction counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin program execution.
REQ-007 The block SHALL have port halt, input, 1 bit: the decoded HALT instruction is at the current PC.
REQ-008 The block SHALL have port branchType, input, 2 bits: 00 sequential, 01 return, 10 decrement-and-branch-if-not-zero, 11 branch-if-negative.
REQ-009 The block SHALL have port threewireOffset, input, 3 bits: signed offset used by branchType 10.
REQ-010 The block SHALL have port sixwireOffset, input, 6 bits: signed offset used by branchType 11.
REQ-011 The block SHALL have port flag, input, 1 bit: registered ALU condition (zero for type 10, negative for type 11).
REQ-012 The block SHALL have port returnAddr, input, 7 bits: register-A data used by branchType 01.
REQ-013 The block SHALL have port programCounter, output, 7 bits: the current instruction address.
REQ-014 The block SHALL have port execEn, output, 1 bit: high only in RUN; gates regWrite, dataWrite and memOffsetWrite externally.
REQ-015 The block SHALL have port done, output, 1 bit: program halted, result valid.
REQ-016 The block SHALL have port instrCount, output, CNT_W bits: number of instructions retired since the last start.

Function
REQ-017 The state machine SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 SHALL move the block to RUN, load the PC with START_PC and clear instrCount.
REQ-019 In RUN with halt=1, the block SHALL move to DONE, hold the PC and increment instrCount once. halt SHALL take priority over any branchType value.
REQ-020 In RUN with halt=0, the PC SHALL update every cycle and instrCount SHALL increment by 1.
REQ-021 In RUN, the next PC SHALL be selected by branchType as follows:
- 00: PC+1.
- 01: returnAddr.
- 10: if flag=0, PC+sext(threewireOffset); otherwise PC+1.
- 11: if flag=1, PC+sext(sixwireOffset); otherwise PC+1.
REQ-022 All PC arithmetic SHALL be 7-bit modulo 128; both wrap directions are legal and no error is raised.
REQ-023 instrCount SHALL saturate at all-ones and SHALL NOT wrap.
REQ-024 In DONE, done SHALL be 1, and PC and instrCount SHALL hold. start=1 SHALL behave exactly as REQ-018.
REQ-025 start SHALL be ignored while in RUN.
REQ-026 execEn SHALL be a combinational decode of state=RUN; done SHALL be a combinational decode of state=DONE. Neither output SHALL have added latency.
REQ-027 A branch target SHALL take effect with one-cycle latency: the PC shows the target on the cycle after the branch is presented.

Reset
REQ-028 reset=1 SHALL take priority over all other inputs, including start and halt.
REQ-029 On reset the block SHALL enter state IDLE with programCounter=START_PC, instrCount=0, execEn=0 and done=0.
REQ-030 Reset asserted mid-RUN SHALL abort the program on the next edge; no partial instrCount update SHALL occur.

Structure
REQ-031 The branchType encodings (BR_NONE, BR_RET, BR_DBNZ, BR_BN) and the state enum SHALL live in the shared definitions package.
REQ-032 A sub-module pc_next (purely combinational next-PC selection and adder) SHALL be used; state, PC register and counter logic SHALL remain in pc_sequencer.

Verification
REQ-033 The bench SHALL cover each of the following scenarios:
- Reset, then start pulse, then 5 cycles with branchType=00: PC goes 0,1,2,3,4,5; instrCount=5; execEn=1.
- At PC=10, branchType=10, threewireOffset=3'b101, flag=0: next PC=7. The same with flag=1: next PC=11.
- At PC=2, branchType=11, sixwireOffset=6'b111100, flag=1: next PC=126 (wrap). At PC=127 with branchType=00: next PC=0.
- At PC=40, branchType=01, returnAddr=7'd100: next PC=100. Then halt=1 with branchType=11 and flag=1: state DONE, PC held at 100, done=1, execEn=0.
- start pulsed during RUN: no effect. Reset asserted mid-RUN: IDLE, PC=0, instrCount=0 on the next cycle.
- With CNT_W=4, run 20 sequential instructions: instrCount saturates at 15.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: PC width,
// branch-type encodings and the sequencer state enum.
package pc_sequencer_pkg;

    localparam int PC_W = 7;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,  // sequential, PC+1
        BR_RET  = 2'b01,  // jump to register-A data
        BR_DBNZ = 2'b10,  // relative branch when zero flag is clear
        BR_BN   = 2'b11   // relative branch when negative flag is set
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Sign-extend a narrow offset to PC width.
    function automatic logic [PC_W-1:0] sext3(input logic [2:0] off);
        return {{(PC_W-3){off[2]}}, off};
    endfunction

    function automatic logic [PC_W-1:0] sext6(input logic [5:0] off);
        return {{(PC_W-6){off[5]}}, off};
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Purely combinational next-PC selection. All arithmetic wraps modulo 128.
module pc_next
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      branch_type,
    input  logic [2:0]      off3,
    input  logic [5:0]      off6,
    input  logic            flag,
    input  logic [PC_W-1:0] ret_addr,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel3;
    logic [PC_W-1:0] pc_rel6;

    // Candidate targets; overflow of the 7-bit sums is the intended wrap.
    always_comb begin
        pc_inc  = pc + PC_W'(1);
        pc_rel3 = pc + sext3(off3);
        pc_rel6 = pc + sext6(off6);
    end

    // Select the target by branch type and flag sense.
    always_comb begin
        next_pc = pc_inc;
        case (br_type_e'(branch_type))
            BR_NONE: next_pc = pc_inc;
            BR_RET:  next_pc = ret_addr;
            BR_DBNZ: next_pc = flag ? pc_inc : pc_rel3;
            BR_BN:   next_pc = flag ? pc_rel6 : pc_inc;
            default: next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, PC register and a
// saturating retired-instruction counter. Next-PC math lives in pc_next.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [6:0] START_PC = 7'd0,
    parameter int         CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic [1:0]       branchType,
    input  logic [2:0]       threewireOffset,
    input  logic [5:0]       sixwireOffset,
    input  logic             flag,
    input  logic [6:0]       returnAddr,
    output logic [6:0]       programCounter,
    output logic             execEn,
    output logic             done,
    output logic [CNT_W-1:0] instrCount
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [PC_W-1:0]  next_pc;

    pc_next u_pc_next (
        .pc          (pc_q),
        .branch_type (branchType),
        .off3        (threewireOffset),
        .off6        (sixwireOffset),
        .flag        (flag),
        .ret_addr    (returnAddr),
        .next_pc     (next_pc)
    );

    // Saturating increment: the counter sticks at all-ones.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state, PC and counter selection; halt wins over any branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (halt) begin
                    state_d = DONE;
                end else begin
                    pc_d = next_pc;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset overrides everything else on the same edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode the current state with no extra latency.
    always_comb begin
        execEn         = (state_q == RUN);
        done           = (state_q == DONE);
        programCounter = pc_q;
        instrCount     = cnt_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table plus a
// hand-written saturation run against a narrow-counter instance.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        reset, start, halt, flag;
    logic [1:0]  branchType;
    logic [2:0]  threewireOffset;
    logic [5:0]  sixwireOffset;
    logic [6:0]  returnAddr;

    logic [6:0]  pc16, pc4;
    logic        en16, en4, dn16, dn4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.START_PC(7'd0), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .start(start), .halt(halt),
        .branchType(branchType), .threewireOffset(threewireOffset),
        .sixwireOffset(sixwireOffset), .flag(flag), .returnAddr(returnAddr),
        .programCounter(pc16), .execEn(en16), .done(dn16), .instrCount(cnt16)
    );

    pc_sequencer #(.START_PC(7'd0), .CNT_W(4)) dut4 (
        .CLK(CLK), .reset(reset), .start(start), .halt(halt),
        .branchType(branchType), .threewireOffset(threewireOffset),
        .sixwireOffset(sixwireOffset), .flag(flag), .returnAddr(returnAddr),
        .programCounter(pc4), .execEn(en4), .done(dn4), .instrCount(cnt4)
    );

    typedef struct {
        logic       rst, st, hlt;
        logic [1:0] bt;
        logic [2:0] o3;
        logic [5:0] o6;
        logic       fl;
        logic [6:0] ra;
        int         e_pc, e_cnt;
        logic       e_en, e_dn;
    } vec_t;

    function automatic vec_t mk(logic rst, logic st, logic hlt, logic [1:0] bt,
                                logic [2:0] o3, logic [5:0] o6, logic fl,
                                logic [6:0] ra, int e_pc, int e_cnt,
                                logic e_en, logic e_dn);
        vec_t v;
        v.rst = rst; v.st = st; v.hlt = hlt; v.bt = bt; v.o3 = o3; v.o6 = o6;
        v.fl = fl; v.ra = ra; v.e_pc = e_pc; v.e_cnt = e_cnt;
        v.e_en = e_en; v.e_dn = e_dn;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic hlt,
                         input logic [1:0] bt, input logic [2:0] o3,
                         input logic [5:0] o6, input logic fl, input logic [6:0] ra);
        @(negedge CLK);
        reset = rst; start = st; halt = hlt; branchType = bt;
        threewireOffset = o3; sixwireOffset = o6; flag = fl; returnAddr = ra;
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[27];

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; branchType = 2'b00;
        threewireOffset = 3'b000; sixwireOffset = 6'b000000; flag = 1'b0;
        returnAddr = 7'd0;

        //           rst st hlt bt     o3      o6         fl  ra      pc  cnt en dn
        vecs[0]  = mk(1, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0,  0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0,  0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   1,  1, 1, 0);
        vecs[4]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   2,  2, 1, 0);
        vecs[5]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   3,  3, 1, 0);
        vecs[6]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   4,  4, 1, 0);
        vecs[7]  = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   5,  5, 1, 0);
        // start during RUN is ignored
        vecs[8]  = mk(0, 1, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   6,  6, 1, 0);
        vecs[9]  = mk(0, 0, 0, 2'b01, 3'b000, 6'b000000, 0, 7'd10, 10,  7, 1, 0);
        vecs[10] = mk(0, 0, 0, 2'b10, 3'b101, 6'b000000, 0, 7'd0,   7,  8, 1, 0);
        vecs[11] = mk(0, 0, 0, 2'b01, 3'b000, 6'b000000, 0, 7'd10, 10,  9, 1, 0);
        vecs[12] = mk(0, 0, 0, 2'b10, 3'b101, 6'b000000, 1, 7'd0,  11, 10, 1, 0);
        vecs[13] = mk(0, 0, 0, 2'b01, 3'b000, 6'b000000, 0, 7'd2,   2, 11, 1, 0);
        vecs[14] = mk(0, 0, 0, 2'b11, 3'b000, 6'b111100, 1, 7'd0, 126, 12, 1, 0);
        vecs[15] = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0, 127, 13, 1, 0);
        vecs[16] = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0, 14, 1, 0);
        vecs[17] = mk(0, 0, 0, 2'b11, 3'b000, 6'b111100, 0, 7'd0,   1, 15, 1, 0);
        vecs[18] = mk(0, 0, 0, 2'b01, 3'b000, 6'b000000, 0, 7'd40, 40, 16, 1, 0);
        vecs[19] = mk(0, 0, 0, 2'b01, 3'b000, 6'b000000, 0, 7'd100,100, 17, 1, 0);
        // halt beats a taken branch
        vecs[20] = mk(0, 0, 1, 2'b11, 3'b000, 6'b111100, 1, 7'd0, 100, 18, 0, 1);
        vecs[21] = mk(0, 0, 1, 2'b00, 3'b000, 6'b000000, 0, 7'd0, 100, 18, 0, 1);
        // restart from DONE
        vecs[22] = mk(0, 1, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0,  0, 1, 0);
        vecs[23] = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   1,  1, 1, 0);
        vecs[24] = mk(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   2,  2, 1, 0);
        // reset mid-RUN wins over start and halt
        vecs[25] = mk(1, 1, 1, 2'b01, 3'b000, 6'b000000, 0, 7'd50,  0,  0, 0, 0);
        vecs[26] = mk(0, 0, 1, 2'b00, 3'b000, 6'b000000, 0, 7'd0,   0,  0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].hlt, vecs[i].bt,
                  vecs[i].o3, vecs[i].o6, vecs[i].fl, vecs[i].ra);
            check($sformatf("v%0d pc", i),     int'(pc16),  vecs[i].e_pc);
            check($sformatf("v%0d cnt", i),    int'(cnt16), vecs[i].e_cnt);
            check($sformatf("v%0d execEn", i), int'(en16),  int'(vecs[i].e_en));
            check($sformatf("v%0d done", i),   int'(dn16),  int'(vecs[i].e_dn));
        end

        // Saturation: narrow counter stops at 15, wide counter keeps going.
        drive(1, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0);
        check("sat reset cnt4", int'(cnt4), 0);
        drive(0, 1, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0);
        check("sat start cnt4", int'(cnt4), 0);
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, 0, 2'b00, 3'b000, 6'b000000, 0, 7'd0);
            check($sformatf("sat n%0d cnt4", n),  int'(cnt4),  (n > 15) ? 15 : n);
            check($sformatf("sat n%0d cnt16", n), int'(cnt16), n);
            check($sformatf("sat n%0d pc4", n),   int'(pc4),   n);
        end
        // halt at saturation keeps the counter pinned
        drive(0, 0, 1, 2'b00, 3'b000, 6'b000000, 0, 7'd0);
        check("sat halt cnt4", int'(cnt4), 15);
        check("sat halt done4", int'(dn4), 1);
        check("sat halt en4", int'(en4), 0);
        check("sat halt pc4", int'(pc4), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
